// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Responder side of the CPU data-memory interface. It accepts one load or store
// at a time from the EX-stage initiator and models a multi-cycle, word-addressed
// memory. Each access is answered with a one-cycle ack that carries either the
// read data or an error flag. While an access is in flight, stall_o holds the
// requester's pipeline registers.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words stored (power of two, >= 4)
//   LATENCY     : BUSY cycles between accept and ack (1..15)
//
// Ports
//   clk_i   in   1   clock, rising edge
//   rst_n   in   1   asynchronous active-low reset
//   req_i   in   1   access request, held by the requester until ack_o
//   we_i    in   1   1 = store, 0 = load (sampled with req_i)
//   addr_i  in   32  byte address (sampled with req_i)
//   wdata_i in   32  store data (sampled with req_i)
//   rdata_o out  32  load data, valid while ack_o = 1
//   ack_o   out  1   one-cycle completion pulse
//   err_o   out  1   misaligned or out-of-range access, valid while ack_o = 1
//   stall_o out  1   requester must hold its pipeline while high
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nxt_s;
  logic        accept_s;
  logic        finish_s;
  logic        stall_s;

  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;

  logic        acc_err_s;
  logic [AW-1:0] idx_s;

  // Storage is deliberately left out of reset so that contents survive it.
  logic [31:0] mem_r [DEPTH_WORDS];

  // An access is illegal when it is not word aligned or its word index falls
  // beyond the array. Out-of-range words must not alias onto low words.
  function automatic logic addr_is_bad(input logic [31:0] a);
    logic bad;
    bad = 1'b0;
    if (a[1:0] != 2'b00) begin
      bad = 1'b1;
    end else if (a[31:2] >= 30'(DEPTH_WORDS)) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  assign acc_err_s = addr_is_bad(addr_r);
  assign idx_s     = addr_r[AW+1:2];
  assign stall_o   = stall_s;

  // Next-state, counter and control strobes for the access sequencer.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    finish_s    = 1'b0;
    stall_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_i) begin
          state_nxt_s = ST_BUSY;
          cnt_nxt_s   = 4'(LATENCY - 1);
          accept_s    = 1'b1;
          stall_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall_s = 1'b1;
        if (cnt_r != 4'd0) begin
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          state_nxt_s = ST_DONE;
          finish_s    = 1'b1;
        end
      end
      // Exactly one cycle; a req_i still high here belongs to the access
      // that is completing, so it is not treated as a new request.
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Capture the request on accept. Later changes on the inputs are ignored.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
    end else if (accept_s) begin
      we_r    <= we_i;
      addr_r  <= addr_i;
      wdata_r <= wdata_i;
    end
  end

  // Array write on completion of a legal store. Reset forces the sequencer to
  // IDLE, so finish_s cannot fire and an in-flight store is dropped.
  always_ff @(posedge clk_i) begin
    if (finish_s && we_r && !acc_err_s) begin
      mem_r[idx_s] <= wdata_r;
    end
  end

  // Registered response. It is driven on the BUSY->DONE edge and cleared on
  // the edge that leaves DONE.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
    end else if (finish_s) begin
      ack_o   <= 1'b1;
      err_o   <= acc_err_s;
      rdata_o <= (acc_err_s || we_r) ? 32'd0 : mem_r[idx_s];
    end else begin
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder. It applies a table of directed
// accesses, then hand-written reset, held-request and input-change sequences,
// then randomized accesses. Results are checked against an associative-array
// memory model.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH = 128;
  localparam int LAT   = 2;

  logic        clk_i;
  logic        rst_n;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        err_o;
  logic        stall_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference memory: only words written through the bench are known.
  logic [31:0] mem_m [int];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .ack_o   (ack_o),
    .err_o   (err_o),
    .stall_o (stall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic model_err(input logic [31:0] a);
    return ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= 32'(DEPTH));
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One full access. It checks latency, stall profile and single-cycle ack, and
  // returns the response fields. The caller is about 1 time unit after a rising edge.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic er);
    int cyc;
    int stall_cnt;
    bit got;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wdata;
    req_i   = 1'b1;
    #1;
    stall_cnt = stall_o ? 1 : 0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (ack_o) got = 1'b1;
      else if (stall_o) stall_cnt++;
    end
    chk("ack_latency", 32'(cyc), 32'(LAT + 1));
    chk("stall_cycles", 32'(stall_cnt), 32'(LAT + 1));
    chk("stall_in_done", {31'd0, stall_o}, 32'd0);
    rd    = rdata_o;
    er    = err_o;
    req_i = 1'b0;
    tick();
    chk("ack_one_cycle", {31'd0, ack_o}, 32'd0);
  endtask

  // Access that also predicts the result from the model and updates it.
  task automatic model_access(input string name, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata);
    logic [31:0] rd;
    logic        er;
    logic        e_err;
    int          w;
    e_err = model_err(addr);
    w     = int'(addr / 32'd4);
    do_access(we, addr, wdata, rd, er);
    chk({name, "_err"}, {31'd0, er}, {31'd0, e_err});
    if (e_err || we) begin
      chk({name, "_rdata0"}, rd, 32'd0);
    end else if (mem_m.exists(w)) begin
      chk({name, "_rdata"}, rd, mem_m[w]);
    end
    if (we && !e_err) mem_m[w] = wdata;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] vals [4];
    int          acks;
    int          last;
    int          cyc;
    bit          got;
    logic        rw;
    logic [31:0] raddr;
    int          sel;
    int          gap;

    rst_n   = 1'b0;
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = 32'd0;
    wdata_i = 32'd0;
    #2;
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed table: stores, loads, misaligned and out-of-range accesses.
    vecs.push_back('{1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h1234_5678});
    vecs.push_back('{1'b0, 32'h0000_0022, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0021, 32'hFFFF_FFFF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h1234_5678});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'(DEPTH * 4), 32'hFFFF_FFFF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_A5A5});
    vecs.push_back('{1'b1, 32'(DEPTH * 4 - 4), 32'hCAFE_F00D, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'(DEPTH * 4 - 4), 32'h0,     1'b0, 32'hCAFE_F00D});
    vecs.push_back('{1'b0, 32'(DEPTH * 4), 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0});
    foreach (vecs[i]) begin
      do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      if (vecs[i].we && !vecs[i].exp_err) mem_m[int'(vecs[i].addr / 32'd4)] = vecs[i].wdata;
    end

    // Reset in the middle of a store: no ack, no write.
    model_access("pre_rst_store", 1'b1, 32'h10, 32'h1111_2222);
    we_i    = 1'b1;
    addr_i  = 32'h10;
    wdata_i = 32'hDEAD_BEEF;
    req_i   = 1'b1;
    tick();
    rst_n = 1'b0;
    req_i = 1'b0;
    #1;
    chk("midrst_ack", {31'd0, ack_o}, 32'd0);
    chk("midrst_err", {31'd0, err_o}, 32'd0);
    chk("midrst_rdata", rdata_o, 32'd0);
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_noack", {31'd0, ack_o}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("postrst_noack", {31'd0, ack_o}, 32'd0);
      chk("postrst_stall", {31'd0, stall_o}, 32'd0);
    end
    model_access("postrst_load", 1'b0, 32'h10, 32'h0);

    // req_i held high across four loads, address moved after each ack.
    for (int k = 0; k < 4; k++) begin
      vals[k] = 32'hC0DE_0000 | 32'(k * 17);
      model_access("burst_fill", 1'b1, 32'(k * 4), vals[k]);
    end
    we_i   = 1'b0;
    addr_i = 32'h0;
    req_i  = 1'b1;
    acks   = 0;
    last   = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (ack_o) begin
        chk("burst_err", {31'd0, err_o}, 32'd0);
        chk("burst_rdata", rdata_o, vals[acks]);
        if (acks == 0) chk("burst_first", 32'(c), 32'(LAT));
        else chk("burst_spacing", 32'(c - last), 32'(LAT + 2));
        last = c;
        acks++;
        if (acks < 4) addr_i = 32'(acks * 4);
        else req_i = 1'b0;
      end
    end
    chk("burst_count", 32'(acks), 32'd4);
    req_i = 1'b0;
    tick();

    // Inputs changing during BUSY: the access completes with latched values.
    model_access("chg_pre", 1'b1, 32'h34, 32'h0BAD_CAFE);
    we_i    = 1'b1;
    addr_i  = 32'h30;
    wdata_i = 32'h600D_F00D;
    req_i   = 1'b1;
    tick();
    we_i    = 1'b0;
    addr_i  = 32'h35;
    wdata_i = 32'h1111_1111;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      tick();
      cyc++;
      if (ack_o) got = 1'b1;
    end
    chk("chg_latency", 32'(cyc), 32'(LAT));
    chk("chg_err", {31'd0, err_o}, 32'd0);
    chk("chg_rdata", rdata_o, 32'd0);
    req_i = 1'b0;
    tick();
    mem_m[32'h30 / 4] = 32'h600D_F00D;
    model_access("chg_load30", 1'b0, 32'h30, 32'h0);
    model_access("chg_load34", 1'b0, 32'h34, 32'h0);

    // Randomized accesses against the model.
    for (int i = 0; i < 60; i++) begin
      rw  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 7));
      if (sel == 0) raddr = $urandom;
      else if (sel == 1) raddr = 32'($urandom_range(0, DEPTH + 3) * 4 + $urandom_range(1, 3));
      else raddr = 32'($urandom_range(0, DEPTH + 3) * 4);
      model_access("rnd", rw, raddr, $urandom);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
